fact_ctrl: RTL

FACT_CTRL -- requirements
Module: fact_ctrl

---
 rtl/fact_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/fact_ctrl.sv
// Control FSM for an iterative factorial datapath: sequences counter/product loads,
// bounds the number of multiply iterations and runs a four-phase Go/Done|Err handshake.
module fact_ctrl #(
  parameter int ITER_MAX = 16,
  parameter int ITW      = 5
) (
  input  logic CLK,
  input  logic rst,
  input  logic Go,
  input  logic GT,
  input  logic Err_in,
  output logic Load_count,
  output logic EN,
  output logic Load_reg,
  output logic Sel,
  output logic Done,
  output logic Err,
  output logic Busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHK  = 3'd1,
    LOAD = 3'd2,
    WAIT = 3'd3,
    CMP  = 3'd4,
    MUL  = 3'd5,
    DONE = 3'd6,
    ERR  = 3'd7
  } state_t;

  localparam logic [ITW-1:0] ITER_LAST = ITW'(ITER_MAX - 1);

  state_t         state_r;
  state_t         next_s;
  logic [ITW-1:0] iter_r;

  // Output bundle {Load_count, EN, Load_reg, Sel, Done, Err, Busy} for a given state.
  function automatic logic [6:0] decode(input state_t s);
    case (s)
      IDLE:    decode = 7'b000_0000;
      CHK:     decode = 7'b000_0001;
      LOAD:    decode = 7'b111_1001;
      WAIT:    decode = 7'b000_0001;
      CMP:     decode = 7'b000_0001;
      MUL:     decode = 7'b011_0001;
      DONE:    decode = 7'b000_0100;
      ERR:     decode = 7'b000_0010;
      default: decode = 7'b000_0000;
    endcase
  endfunction

  // Next-state selection.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (Go) next_s = CHK;
        else    next_s = IDLE;
      end
      CHK: begin
        if (Err_in) next_s = ERR;
        else        next_s = LOAD;
      end
      LOAD: next_s = WAIT;
      WAIT: next_s = CMP;
      CMP: begin
        if (GT) next_s = MUL;
        else    next_s = DONE;
      end
      MUL: begin
        if (iter_r == ITER_LAST) next_s = ERR;
        else                     next_s = WAIT;
      end
      DONE: begin
        if (Go) next_s = DONE;
        else    next_s = IDLE;
      end
      ERR: begin
        if (Go) next_s = ERR;
        else    next_s = IDLE;
      end
      default: next_s = IDLE;
    endcase
  end

  // State, iteration counter and outputs; outputs are registered from the incoming state
  // so they always equal the decode of the current state register.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_r <= IDLE;
      iter_r  <= '0;
      {Load_count, EN, Load_reg, Sel, Done, Err, Busy} <= 7'b000_0000;
    end else begin
      state_r <= next_s;
      if (state_r == LOAD) begin
        iter_r <= '0;
      end else if (state_r == MUL) begin
        iter_r <= iter_r + ITW'(1);
      end else begin
        iter_r <= iter_r;
      end
      {Load_count, EN, Load_reg, Sel, Done, Err, Busy} <= decode(next_s);
    end
  end

endmodule
